// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: byte-write side and transmitter handshake of the UART TX feeder.
// The slave modport is the feeder itself. The master modport is the surrounding
// system: the application that writes bytes and the transmitter that reports
// tx_active.
interface uart_tx_feeder_if #(
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic              tx_active;
   logic              busy;
   logic              done;
   logic              ovf;

   modport slave (
      input  wr_en, wr_data, tx_active,
      output full, empty, count, tx_dv, tx_byte, busy, done, ovf
   );

   modport master (
      output wr_en, wr_data, tx_active,
      input  full, empty, count, tx_dv, tx_byte, busy, done, ovf
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular byte FIFO plus a four-state sequencer that hands bytes
// to a UART transmitter one at a time. Each byte is issued with a one-cycle tx_dv
// pulse. The next byte is not issued until the transmitter has raised and then
// dropped tx_active.
// Optional feature: define UART_TX_FEEDER_OVF_EN to build the sticky overflow flag.
// Without it, ovf is tied to 0. Writes while full are dropped in both builds.
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input logic             clk,
   input logic             rst_n,
   uart_tx_feeder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_ACT  = 2'd2,
      WAIT_DONE = 2'd3
   } stateT;

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   stateT             state;
   stateT             stateNext;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cntNext;
   logic              fullQ;
   logic              emptyQ;

   logic [7:0]        txByteQ;
   logic              txDvQ;
   logic              doneQ;

   logic              pushNow;
   logic              popNow;
   logic              txDvNext;
   logic              doneNext;

   // A write while full is dropped even if a pop frees a slot on the same edge.
   assign pushNow = bus.wr_en && !fullQ;

   // State register; reset returns to IDLE at once, whatever is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: pop and raise tx_dv leaving IDLE, and pulse done when the
   // transmitter's active flag has fallen.
   always_comb begin
      stateNext = state;
      popNow    = 1'b0;
      txDvNext  = 1'b0;
      doneNext  = 1'b0;
      case (state)
         IDLE: begin
            if (!emptyQ) begin
               popNow    = 1'b1;
               txDvNext  = 1'b1;
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            stateNext = WAIT_ACT;
         end
         WAIT_ACT: begin
            if (bus.tx_active) begin
               stateNext = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_active) begin
               doneNext  = 1'b1;
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Occupancy after this edge: a simultaneous push and pop cancel out.
   always_comb begin
      cntNext = cnt;
      case ({pushNow, popNow})
         2'b10:   cntNext = cnt + CNT_ONE;
         2'b01:   cntNext = cnt - CNT_ONE;
         default: cntNext = cnt;
      endcase
   end

   // Pointers, count and the registered full/empty flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         cnt    <= '0;
         fullQ  <= 1'b0;
         emptyQ <= 1'b1;
      end else begin
         if (pushNow) begin
            wrPtr <= wrPtr + PTR_ONE;
         end
         if (popNow) begin
            rdPtr <= rdPtr + PTR_ONE;
         end
         cnt    <= cntNext;
         fullQ  <= (cntNext == FULL_CNT);
         emptyQ <= (cntNext == '0);
      end
   end

   // Byte storage is never reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (pushNow) begin
         mem[wrPtr] <= bus.wr_data;
      end
   end

   // Transmitter-side outputs: tx_byte holds the last issued byte, while tx_dv and
   // done are single-cycle pulses cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txByteQ <= 8'h00;
         txDvQ   <= 1'b0;
         doneQ   <= 1'b0;
      end else begin
         if (popNow) begin
            txByteQ <= mem[rdPtr];
         end
         txDvQ <= txDvNext;
         doneQ <= doneNext;
      end
   end

`ifdef UART_TX_FEEDER_OVF_EN
   logic ovfQ;

   // Sticky overflow: any write attempt while full sets it; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovfQ <= 1'b0;
      end else if (bus.wr_en && fullQ) begin
         ovfQ <= 1'b1;
      end
   end

   assign bus.ovf = ovfQ;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.full    = fullQ;
   assign bus.empty   = emptyQ;
   assign bus.count   = cnt;
   assign bus.tx_dv   = txDvQ;
   assign bus.tx_byte = txByteQ;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = doneQ;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder with a simple UART
// transmitter model. The model has three modes: normal framing, stalled active,
// and dead (it never raises tx_active).
module tb_uart_tx_feeder;

   localparam int DEPTH        = 16;
   localparam int ADDR_W       = 4;
   localparam int CLKS_PER_BIT = 4;
   localparam int FRAME        = 10 * CLKS_PER_BIT;
`ifdef UART_TX_FEEDER_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus();

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int         total = 0;
   int         bad = 0;
   int         dvCount = 0;
   int         doneCount = 0;
   logic [7:0] sbQ [$];
   logic [7:0] expByte;
   logic       prevDv = 1'b0;

   // Transmitter model: 0 = normal, 1 = hold active, 2 = dead
   int   txMode = 0;
   int   txState = 0;
   int   txCnt = 0;
   logic txActive = 1'b0;
   assign bus.tx_active = txActive;

   // Transmitter model: idle -> active for a frame -> one cleanup cycle -> idle
   always @(posedge clk) begin
      case (txState)
         0: begin
            if (bus.tx_dv === 1'b1 && txMode != 2) begin
               txActive <= 1'b1;
               txCnt    <= 0;
               txState  <= 1;
            end
         end
         1: begin
            if (txMode != 1) begin
               if (txCnt == FRAME - 1) begin
                  txActive <= 1'b0;
                  txState  <= 2;
               end else begin
                  txCnt <= txCnt + 1;
               end
            end
         end
         default: txState <= 0;
      endcase
   end

   // Scoreboard monitor: every issue must match the queue, find the model idle, and last one cycle
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.tx_dv === 1'b1) begin
            dvCount++;
            total++;
            if (sbQ.size() == 0) begin
               bad++;
               $display("FAIL issue_unexpected: got tx_byte=%h, required no issue", bus.tx_byte);
            end else begin
               expByte = sbQ.pop_front();
               if (bus.tx_byte !== expByte) begin
                  bad++;
                  $display("FAIL issue_byte: got %h, required %h", bus.tx_byte, expByte);
               end
            end
            total++;
            if (txState != 0) begin
               bad++;
               $display("FAIL issue_while_tx_busy: tx model state=%0d, required 0", txState);
            end
            total++;
            if (prevDv) begin
               bad++;
               $display("FAIL dv_width: tx_dv high 2 cycles, required 1");
            end
         end
         if (bus.done === 1'b1) doneCount++;
      end
      prevDv = (rst_n === 1'b1) && (bus.tx_dv === 1'b1);
   end

   task automatic writeByte(input logic [7:0] b, input bit keep);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      if (keep) sbQ.push_back(b);
   endtask

   task automatic waitCounts(input int dvT, input int doneT, input int budget, output bit ok);
      int n;
      n = 0;
      while ((dvCount < dvT || doneCount < doneT) && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (dvCount >= dvT) && (doneCount >= doneT);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.tx_dv !== 1'b0) begin bad++; $display("FAIL rst_tx_dv: got %b, required 0", bus.tx_dv); end
      total++; if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %h, required 00", bus.tx_byte); end
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d, required 0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b, required 1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b, required 0", bus.full); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b, required 0", bus.done); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b, required 0", bus.ovf); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit seen;
      bit busyDrop;
      writeByte(8'hA5, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count1: got %0d, required 1", bus.count); end
      total++; if (bus.tx_dv !== 1'b0) begin bad++; $display("FAIL single_dv_early: got %b, required 0", bus.tx_dv); end
      @(negedge clk);
      total++; if (bus.tx_dv !== 1'b1) begin bad++; $display("FAIL single_dv: got %b, required 1", bus.tx_dv); end
      total++; if (bus.tx_byte !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h, required a5", bus.tx_byte); end
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count0: got %0d, required 0", bus.count); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b, required 1", bus.busy); end
      @(negedge clk);
      total++; if (bus.tx_dv !== 1'b0) begin bad++; $display("FAIL single_dv_fall: got %b, required 0", bus.tx_dv); end
      seen = 1'b0;
      busyDrop = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy !== 1'b1) busyDrop = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL single_done_timeout: got no done in 200 cycles, required a pulse"); end
      total++; if (busyDrop) begin bad++; $display("FAIL single_busy_hold: got busy=0 before done, required 1"); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b, required 0", bus.busy); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b, required 0", bus.done); end
   endtask

   task automatic test_back_to_back();
      int dv0;
      int dn0;
      bit ok;
      dv0 = dvCount;
      dn0 = doneCount;
      writeByte(8'h01, 1'b1);
      writeByte(8'h02, 1'b1);
      writeByte(8'h03, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      waitCounts(dv0 + 3, dn0 + 3, 600, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got dv=%0d done=%0d, required 3 each", dvCount - dv0, doneCount - dn0); end
      total++; if (sbQ.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d pending, required 0", sbQ.size()); end
   endtask

   task automatic test_fill();
      int dv0;
      int dn0;
      int n;
      bit ok;
      dv0 = dvCount;
      dn0 = doneCount;
      txMode = 1;
      writeByte(8'h10, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      n = 0;
      while (txActive !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (txActive !== 1'b1) begin bad++; $display("FAIL fill_active_timeout: got tx_active=%b, required 1", txActive); end
      for (int i = 0; i < DEPTH; i++) writeByte(8'h20 + 8'(i), 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b, required 1", bus.full); end
      total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_count: got %0d, required 16", bus.count); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf_pre: got %b, required 0", bus.ovf); end
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hFF;
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_count_drop: got %0d, required 16", bus.count); end
      total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full_drop: got %b, required 1", bus.full); end
      total++; if (bus.ovf !== OVF_EXP) begin bad++; $display("FAIL fill_ovf: got %b, required %b", bus.ovf, OVF_EXP); end
      txMode = 0;
      waitCounts(dv0 + 17, dn0 + 17, 2500, ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_drain_timeout: got dv=%0d, required 17", dvCount - dv0); end
      total++; if (sbQ.size() != 0) begin bad++; $display("FAIL fill_left: got %0d pending, required 0", sbQ.size()); end
      repeat (60) @(negedge clk);
      total++; if (dvCount != dv0 + 17) begin bad++; $display("FAIL fill_extra_issue: got %0d issues, required 17", dvCount - dv0); end
      total++; if (bus.ovf !== OVF_EXP) begin bad++; $display("FAIL fill_ovf_sticky: got %b, required %b", bus.ovf, OVF_EXP); end
   endtask

   task automatic test_wrap();
      int dv0;
      int dn0;
      int sent;
      int budget;
      bit ok;
      dv0 = dvCount;
      dn0 = doneCount;
      sent = 0;
      budget = 6000;
      while (sent < 40 && budget > 0) begin
         @(negedge clk);
         if (bus.full === 1'b0) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(sent);
            sbQ.push_back(8'(sent));
            sent++;
         end else begin
            bus.wr_en = 1'b0;
         end
         budget--;
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (sent != 40) begin bad++; $display("FAIL wrap_sent: got %0d, required 40", sent); end
      waitCounts(dv0 + 40, dn0 + 40, 3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got dv=%0d, required 40", dvCount - dv0); end
      total++; if (sbQ.size() != 0) begin bad++; $display("FAIL wrap_left: got %0d pending, required 0", sbQ.size()); end
   endtask

   task automatic test_reset_mid();
      int dv0;
      int dn0;
      int n;
      bit ok;
      for (int i = 0; i < 6; i++) writeByte(8'h30 + 8'(i), 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      n = 0;
      while (txActive !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      total++; if (bus.count !== 5'd5) begin bad++; $display("FAIL rmid_count_pre: got %0d, required 5", bus.count); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre: got %b, required 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      total++; if (bus.tx_dv !== 1'b0) begin bad++; $display("FAIL rmid_tx_dv: got %b, required 0", bus.tx_dv); end
      total++; if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL rmid_tx_byte: got %h, required 00", bus.tx_byte); end
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL rmid_count: got %0d, required 0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty: got %b, required 1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rmid_full: got %b, required 0", bus.full); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b, required 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b, required 0", bus.done); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rmid_ovf: got %b, required 0", bus.ovf); end
      sbQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      dv0 = dvCount;
      dn0 = doneCount;
      repeat (100) @(negedge clk);
      total++; if (dvCount != dv0) begin bad++; $display("FAIL rmid_no_issue: got %0d issues, required 0", dvCount - dv0); end
      total++; if (doneCount != dn0) begin bad++; $display("FAIL rmid_no_done: got %0d done, required 0", doneCount - dn0); end
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL rmid_count_post: got %0d, required 0", bus.count); end
      writeByte(8'h5A, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      waitCounts(dv0 + 1, dn0 + 1, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL rmid_new_timeout: got dv=%0d done=%0d, required 1 each", dvCount - dv0, doneCount - dn0); end
      total++; if (sbQ.size() != 0) begin bad++; $display("FAIL rmid_left: got %0d pending, required 0", sbQ.size()); end
   endtask

   task automatic test_stuck();
      int dv0;
      int dn0;
      bit ok;
      bit dvSeen;
      txMode = 2;
      dv0 = dvCount;
      dn0 = doneCount;
      writeByte(8'h77, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      waitCounts(dv0 + 1, dn0, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL stuck_issue_timeout: got dv=%0d, required 1", dvCount - dv0); end
      dvSeen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.tx_dv !== 1'b0) dvSeen = 1'b1;
      end
      total++; if (dvSeen) begin bad++; $display("FAIL stuck_dv: got tx_dv=1 while waiting, required 0"); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stuck_busy: got %b, required 1", bus.busy); end
      for (int i = 0; i < 5; i++) writeByte(8'h80 + 8'(i), 1'b0);
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (bus.count !== 5'd5) begin bad++; $display("FAIL stuck_count: got %0d, required 5", bus.count); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stuck_busy_late: got %b, required 1", bus.busy); end
      total++; if (doneCount != dn0) begin bad++; $display("FAIL stuck_done: got %0d done, required 0", doneCount - dn0); end
      total++; if (dvCount != dv0 + 1) begin bad++; $display("FAIL stuck_issues: got %0d, required 1", dvCount - dv0); end
      rst_n = 1'b0;
      sbQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      txMode = 0;
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_wrap();
      test_reset_mid();
      test_stuck();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
